// File: rtl/go_get_put_monitor.sv
// Multi-channel monitor for: go ##1 get[*GET_REPS] |-> (!stop throughout put[->PUT_GOALS]).
// Optional obligation timeout is built only when GGP_MON_TIMEOUT_EN is defined.

module ggp_mon_chan #(
  parameter int GET_REPS  = 2,
  parameter int PUT_GOALS = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic get,
  input  logic put,
  input  logic stop,
  output logic busy,
  output logic pass,
  output logic fail,
  output logic skip,
  output logic fail_set
);
  localparam int GW = (GET_REPS  > 1) ? $clog2(GET_REPS)  : 1;
  localparam int PW = (PUT_GOALS > 1) ? $clog2(PUT_GOALS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ANTE  = 2'd1;
  localparam logic [1:0] S_OBLIG = 2'd2;

  if (GET_REPS < 1 || PUT_GOALS < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("ggp_mon_chan: GET_REPS, PUT_GOALS and TIMEOUT must all be >= 1");
  end

  logic [1:0]    state, state_d;
  logic [GW-1:0] gcnt, gcnt_d;
  logic [PW-1:0] pcnt, pcnt_d;
  logic          pass_d, skip_d;

`ifdef GGP_MON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt, tcnt_d;
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    state_d  = state;
    gcnt_d   = gcnt;
    pcnt_d   = pcnt;
    pass_d   = 1'b0;
    fail_set = 1'b0;
    // go is only accepted from IDLE, including the cycle an attempt resolves
    skip_d   = go && (state != S_IDLE);
`ifdef GGP_MON_TIMEOUT_EN
    tcnt_d   = tcnt;
`endif
    case (state)
      S_IDLE: begin
        if (go) begin
          state_d = S_ANTE;
          gcnt_d  = '0;
        end
      end
      S_ANTE: begin
        if (!get) begin
          state_d = S_IDLE;
        end else if (gcnt != GW'(GET_REPS - 1)) begin
          gcnt_d = gcnt + 1'b1;
        end else if (stop) begin
          // last get is also the first consequent cycle
          fail_set = 1'b1;
          state_d  = S_IDLE;
        end else if (put && (PUT_GOALS == 1)) begin
          pass_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_OBLIG;
          pcnt_d  = PW'(put);
`ifdef GGP_MON_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      S_OBLIG: begin
        if (stop) begin
          fail_set = 1'b1;
          state_d  = S_IDLE;
        end else if (put && (pcnt == PW'(PUT_GOALS - 1))) begin
          pass_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (put) pcnt_d = pcnt + 1'b1;
`ifdef GGP_MON_TIMEOUT_EN
          if (tcnt == TW'(TIMEOUT - 1)) begin
            fail_set = 1'b1;
            state_d  = S_IDLE;
          end else begin
            tcnt_d = tcnt + 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      gcnt  <= '0;
      pcnt  <= '0;
      pass  <= 1'b0;
      fail  <= 1'b0;
      skip  <= 1'b0;
`ifdef GGP_MON_TIMEOUT_EN
      tcnt  <= '0;
`endif
    end else begin
      state <= state_d;
      gcnt  <= gcnt_d;
      pcnt  <= pcnt_d;
      pass  <= pass_d;
      fail  <= fail_set;
      skip  <= skip_d;
`ifdef GGP_MON_TIMEOUT_EN
      tcnt  <= tcnt_d;
`endif
    end
  end
endmodule

module go_get_put_monitor #(
  parameter int N_CH      = 4,
  parameter int GET_REPS  = 2,
  parameter int PUT_GOALS = 2,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  go,
  input  logic [N_CH-1:0]  get,
  input  logic [N_CH-1:0]  put,
  input  logic [N_CH-1:0]  stop,
  output logic [N_CH-1:0]  busy,
  output logic [N_CH-1:0]  pass,
  output logic [N_CH-1:0]  fail,
  output logic [N_CH-1:0]  skip,
  output logic [CNT_W-1:0] fail_cnt
);
  localparam int NW = $clog2(N_CH + 1);
  localparam int SW = CNT_W + NW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [N_CH-1:0] fail_set;
  logic [NW-1:0]   nfail;
  logic [SW-1:0]   sum;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ggp_mon_chan #(
      .GET_REPS (GET_REPS),
      .PUT_GOALS(PUT_GOALS),
      .TIMEOUT  (TIMEOUT)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .go      (go[i]),
      .get     (get[i]),
      .put     (put[i]),
      .stop    (stop[i]),
      .busy    (busy[i]),
      .pass    (pass[i]),
      .fail    (fail[i]),
      .skip    (skip[i]),
      .fail_set(fail_set[i])
    );
  end

  // counted from next-state fails so the count lands with the fail pulses
  always_comb begin
    nfail = '0;
    for (int i = 0; i < N_CH; i++) nfail = nfail + NW'(fail_set[i]);
    sum = SW'(fail_cnt) + SW'(nfail);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     fail_cnt <= '0;
    else if (sum > SW'(CNT_MAX)) fail_cnt <= CNT_MAX;
    else                         fail_cnt <= sum[CNT_W-1:0];
  end
endmodule

// File: tb/tb_go_get_put_monitor.sv
// Scoreboard bench for go_get_put_monitor: a history-based property model
// queues expected outputs per cycle; a monitor process pops and compares.
module tb_go_get_put_monitor;
  localparam int N = 4, GR = 2, PG = 2, CW = 8, TO = 4, HMAX = 8192;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] go, get, put, stop, busy, pass, fail, skip;
  logic [CW-1:0] fail_cnt;

  go_get_put_monitor #(.N_CH(N), .GET_REPS(GR), .PUT_GOALS(PG), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .get(get), .put(put), .stop(stop),
    .busy(busy), .pass(pass), .fail(fail), .skip(skip), .fail_cnt(fail_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  busy, pass, fail, skip;
    logic [CW-1:0] fcnt;
  } exp_t;

  exp_t q[$];
  int vectors = 0, errors = 0;
  logic [N-1:0] h_get[HMAX], h_put[HMAX], h_stop[HMAX];
  int start[N];
  int cyc = 0;
  int m_fcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Verdict of the attempt accepted at cycle s, judged at cycle c from input history:
  // 0 still open, 1 vacuous, 2 pass, 3 fail
  function automatic int verdict(int ch, int s, int c);
    int k, puts;
    k = c - s;
    puts = 0;
    if (k <= GR && !h_get[c][ch]) return 1;
    if (k < GR) return 0;
    if (h_stop[c][ch]) return 3;
    for (int t = s + GR; t <= c; t++) puts += int'(h_put[t][ch]);
    if (puts >= PG) return 2;
`ifdef GGP_MON_TIMEOUT_EN
    if (c - (s + GR) == TO) return 3;
`endif
    return 0;
  endfunction

  task automatic step(input logic [N-1:0] g, input logic [N-1:0] ge,
                      input logic [N-1:0] p, input logic [N-1:0] st);
    exp_t e;
    int nf;
    nf = 0;
    @(negedge clk);
    go = g; get = ge; put = p; stop = st;
    h_get[cyc] = ge; h_put[cyc] = p; h_stop[cyc] = st;
    e.busy = '0; e.pass = '0; e.fail = '0; e.skip = '0;
    for (int ch = 0; ch < N; ch++) begin
      if (start[ch] < 0) begin
        if (g[ch]) start[ch] = cyc;
      end else begin
        int r;
        e.skip[ch] = g[ch];
        r = verdict(ch, start[ch], cyc);
        if (r != 0) start[ch] = -1;
        e.pass[ch] = (r == 2);
        e.fail[ch] = (r == 3);
        if (r == 3) nf++;
      end
      e.busy[ch] = (start[ch] >= 0);
    end
    m_fcnt = (m_fcnt + nf > CMAX) ? CMAX : m_fcnt + nf;
    e.fcnt = CW'(m_fcnt);
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    go = '0; get = '0; put = '0; stop = '0;
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_skip", 32'(skip), 0);
    chk("rst_fcnt", 32'(fail_cnt), 0);
    for (int ch = 0; ch < N; ch++) start[ch] = -1;
    m_fcnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #2;
    if (!rst && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("busy", 32'(busy), 32'(e.busy));
      chk("pass", 32'(pass), 32'(e.pass));
      chk("fail", 32'(fail), 32'(e.fail));
      chk("skip", 32'(skip), 32'(e.skip));
      chk("fail_cnt", 32'(fail_cnt), 32'(e.fcnt));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] F;
    F = '1;
    go = '0; get = '0; put = '0; stop = '0;
    rst = 1'b0;
    for (int ch = 0; ch < N; ch++) start[ch] = -1;
    #2 rst = 1'b1;
    #1;
    chk("init_busy", 32'(busy), 0);
    chk("init_fcnt", 32'(fail_cnt), 0);
    chk("init_pulses", 32'({pass, fail, skip}), 0);
    @(negedge clk);
    rst = 1'b0;

    // ch0 clean pass: go, get, get, -, put, -, put
    step(4'b0001, 0, 0, 0); step(0, 4'b0001, 0, 0); step(0, 4'b0001, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 4'b0001, 0); step(0, 0, 0, 0); step(0, 0, 4'b0001, 0);
    idle(2);
    // stop mid-obligation, later put ignored
    step(4'b0001, 0, 0, 0); step(0, 4'b0001, 0, 0); step(0, 4'b0001, 0, 0);
    step(0, 0, 0, 0); step(0, 0, 4'b0001, 0); step(0, 0, 0, 4'b0001); step(0, 0, 4'b0001, 0);
    idle(2);
    // vacuous antecedent
    step(4'b0001, 0, 0, 0); step(0, 4'b0001, 0, 0); step(0, 0, 0, 0); idle(2);
    // puts overlapping the last get, then stop on the start cycle
    step(4'b0001, 0, 0, 0); step(0, 4'b0001, 0, 0); step(0, 4'b0001, 4'b0001, 0);
    step(0, 0, 4'b0001, 0); idle(1);
    step(4'b0001, 0, 0, 0); step(0, 4'b0001, 0, 0); step(0, 4'b0001, 0, 4'b0001); idle(1);
    // go while busy, then go on the resolving cycle
    step(4'b0001, 0, 0, 0); step(4'b0001, 4'b0001, 0, 0); step(0, 4'b0001, 4'b0001, 0);
    step(4'b0001, 0, 4'b0001, 0); idle(2);
    // three channels fail together
    step(4'b0111, 0, 0, 0); step(0, 4'b0111, 0, 0); step(0, 4'b0111, 0, 4'b0111); idle(1);
    // reset mid-obligation
    step(F, 0, 0, 0); step(0, F, 0, 0); step(0, F, 0, 0); idle(2);
    do_reset();
    // obligation with no put: timeout build fails, default build stays busy
    step(4'b0010, 0, 0, 0); step(0, 4'b0010, 0, 0); step(0, 4'b0010, 0, 0); idle(8);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] g, ge, p, st;
      for (int ch = 0; ch < N; ch++) begin
        g[ch]  = ($urandom_range(0, 3) == 0);
        ge[ch] = ($urandom_range(0, 3) != 0);
        p[ch]  = ($urandom_range(0, 2) == 0);
        st[ch] = ($urandom_range(0, 9) == 0);
      end
      step(g, ge, p, st);
    end
    idle(12);

    // saturation: 252 + 2 = 254, +3 clamps at 255, +4 stays at 255
    do_reset();
    for (int r = 0; r < 63; r++) begin
      step(F, 0, 0, 0); step(0, F, 0, 0); step(0, F, 0, F); idle(1);
    end
    step(4'b0011, 0, 0, 0); step(0, 4'b0011, 0, 0); step(0, 4'b0011, 0, 4'b0011); idle(1);
    step(4'b0111, 0, 0, 0); step(0, 4'b0111, 0, 0); step(0, 4'b0111, 0, 4'b0111); idle(1);
    step(F, 0, 0, 0); step(0, F, 0, 0); step(0, F, 0, F); idle(2);

    @(posedge clk); @(posedge clk); #3;
    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/go_get_put_monitor.md
# go_get_put_monitor

Synthesizable multi-channel protocol monitor implementing the property `go ##1 get[*GET_REPS] |-> (!stop throughout put[->PUT_GOALS])` as RTL. It is the hardware successor to the fixed-width, single-channel simulation assertion for this handshake. It sits beside the go/get/put/stop handshake fabric and reports per-channel pass/fail pulses and a saturating global failure count. It is usable in emulation and silicon, where SVA is unavailable.

## Interface
- `N_CH`, 4: number of independent channels.
- `GET_REPS`, 2: consecutive `get` cycles required after `go`; must be ≥1.
- `PUT_GOALS`, 2: number of `put` occurrences (non-consecutive) that discharge the obligation; must be ≥1.
- `CNT_W`, 8: width of `fail_cnt`.
- `TIMEOUT`, 64: obligation cycle limit. Used only with `GGP_MON_TIMEOUT_EN`.
- `clk`  in  1  sampling clock; all activity on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `go`  in  N_CH  per-channel trigger.
- `get`  in  N_CH  per-channel antecedent repetition signal.
- `put`  in  N_CH  per-channel goal event.
- `stop`  in  N_CH  per-channel forbidden condition during the obligation.
- `busy`  out  N_CH  channel is tracking an attempt (state ≠ IDLE).
- `pass`  out  N_CH  1-cycle pulse: obligation discharged.
- `fail`  out  N_CH  1-cycle pulse: obligation violated.
- `skip`  out  N_CH  1-cycle pulse: `go` seen while channel busy (attempt not tracked).
- `fail_cnt`  out  CNT_W  total failures over all channels, saturating.

## Operation
- Per channel FSM with states IDLE, ANTE and OBLIG. Counters: `gcnt` (clog2 GET_REPS) and `pcnt` (clog2 PUT_GOALS).
- IDLE: `go`=1 → ANTE, `gcnt`=0. `go` is accepted only in IDLE. In any other state, `go`=1 pulses `skip`. This includes the cycle a channel resolves.
- ANTE, `get`=0 → IDLE silently. The antecedent is unmatched (vacuous), so there is no pass or fail.
- ANTE, `get`=1 and `gcnt`<GET_REPS-1 → `gcnt`++.
- ANTE, `get`=1 and `gcnt`=GET_REPS-1 → the consequent starts in this same cycle (overlapping implication):
  - `stop`=1 → fail, IDLE.
  - else `put`=1 and PUT_GOALS=1 → pass, IDLE.
  - else → OBLIG with `pcnt` = `put`.
- OBLIG: `stop` is checked first.
  - `stop`=1 → fail, IDLE. This applies even when `put` is also 1; the cycle of the final put is inclusive.
  - else `put`=1 and `pcnt`=PUT_GOALS-1 → pass, IDLE.
  - else `put`=1 → `pcnt`++.
- `fail_cnt` adds the popcount of that cycle's `fail` vector. It clamps at 2^CNT_W-1 and never wraps.
- Channels are fully independent; all may resolve in the same cycle.

## Timing
- Reset values: FSMs IDLE, counters 0, `busy`/`pass`/`fail`/`skip` = 0, `fail_cnt` = 0. Reset applies immediately on assertion.
- Reset mid-attempt abandons the attempt with no pulse.
- `pass`/`fail`/`skip` are registered. They are high for exactly the one cycle after the edge that sampled the deciding inputs (latency 1).
- `busy` rises the cycle after `go` is sampled. It falls the cycle after resolution.
- `fail_cnt` updates in the same cycle that `fail` is visible.
- Minimum attempt duration is GET_REPS+1 sampled cycles (`go`, then the gets, with the goal met on the last get).

## Configuration
- `GGP_MON_TIMEOUT_EN` defined:
  - A per-channel counter clears on entering OBLIG and increments each OBLIG cycle.
  - If the obligation is still open after TIMEOUT OBLIG cycles, the channel produces `fail` and returns to IDLE.
  - This counts toward `fail_cnt`.
- `GGP_MON_TIMEOUT_EN` undefined: OBLIG waits indefinitely (strong-less/weak semantics). The TIMEOUT parameter is ignored and no timeout logic is built.

## Test plan
- Ch0: `go`@c0, `get`@c1,c2, `put`@c4,c6, `stop`=0 → `pass[0]` high in c7 only; `busy[0]` high c1–c6; `fail_cnt`=0.
- Same stimulus plus `stop`@c5 → `fail[0]` in c6; `fail_cnt`=1; a later `put`@c6 produces no pass.
- `go`@c0, `get`@c1, `get`=0@c2 → no pulse; `busy[0]` falls in c3.
- `go`@c0, `get`@c1,c2 with `put`@c2,c3 → pass in c4. Repeat with `stop`@c2 → fail in c3 (start cycle included).
- `go`@c1 during an active attempt → `skip[0]` in c2, and the original attempt resolves unaffected. Next, 3 channels fail in the same cycle → `fail_cnt` +3. Preload to 254 with CNT_W=8, then force 3 simultaneous fails → 255 and stays there.
- With `GGP_MON_TIMEOUT_EN` and TIMEOUT=4: enter OBLIG, no `put` → `fail` after 4 OBLIG cycles. Without the macro, the same stimulus leaves `busy` high indefinitely. In both builds, assert `rst` mid-OBLIG → all outputs 0 immediately and no pulse.
